// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter
// Round-robin arbiter and select sequencer for a 4->1 NAND multiplexer.
// Each new select is followed by a settle window before z_valid is raised.
// When other requesters are waiting, a grant is limited to QUANTUM valid cycles.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   req      in   4  request per mux input (req[i] requests d<i>)
//   sel      out  2  registered select to mux4
//   gnt      out  4  registered one-hot grant, all-zero when idle
//   z_valid  out  1  registered: mux output settled and owned by the grantee
//   busy     out  1  registered: arbiter not idle
module mux4_sel_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned QUANTUM       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       z_valid,
  output logic       busy
);

  localparam int unsigned SW = 4;
  localparam int unsigned QW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    last, last_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    gnt_nx;
  logic          z_valid_nx, busy_nx;
  logic [SW-1:0] scnt, scnt_nx;
  logic [QW-1:0] qcnt, qcnt_nx;

  logic [1:0]    win;
  logic          win_found;
  logic          others_waiting;

  // Rotating priority search starting just after the last grantee.
  always_comb begin
    win       = last;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[2'(last + 2'(k))]) begin
        win       = 2'(last + 2'(k));
        win_found = 1'b1;
      end
    end
  end

  assign others_waiting = (req & ~gnt) != 4'b0000;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
      z_valid <= 1'b0;
      busy    <= 1'b0;
      last    <= 2'd3;
      scnt    <= '0;
      qcnt    <= '0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      gnt     <= gnt_nx;
      z_valid <= z_valid_nx;
      busy    <= busy_nx;
      last    <= last_nx;
      scnt    <= scnt_nx;
      qcnt    <= qcnt_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    gnt_nx     = gnt;
    z_valid_nx = z_valid;
    busy_nx    = busy;
    last_nx    = last;
    scnt_nx    = scnt;
    qcnt_nx    = qcnt;

    case (state)
      IDLE: begin
        gnt_nx     = 4'b0000;
        z_valid_nx = 1'b0;
        busy_nx    = 1'b0;
        // sel is left alone when idle to avoid toggling the mux.
        if (win_found) begin
          state_nx = SETTLE;
          sel_nx   = win;
          gnt_nx   = 4'b0001 << win;
          busy_nx  = 1'b1;
          scnt_nx  = SW'(SETTLE_CYCLES - 1);
        end
      end

      SETTLE: begin
        if (!req[sel]) begin
          state_nx   = IDLE;
          gnt_nx     = 4'b0000;
          z_valid_nx = 1'b0;
          busy_nx    = 1'b0;
          last_nx    = sel;
        end else if (scnt == '0) begin
          state_nx   = GRANT;
          z_valid_nx = 1'b1;
          qcnt_nx    = QW'(1);
        end else begin
          scnt_nx = scnt - SW'(1);
        end
      end

      GRANT: begin
        if (!req[sel] ||
            ((QUANTUM != 0) && (qcnt == QW'(QUANTUM)) && others_waiting)) begin
          state_nx   = IDLE;
          gnt_nx     = 4'b0000;
          z_valid_nx = 1'b0;
          busy_nx    = 1'b0;
          last_nx    = sel;
        end else if ((QUANTUM != 0) && (qcnt != QW'(QUANTUM))) begin
          qcnt_nx = qcnt + QW'(1);
        end
      end

      default: begin
        state_nx   = IDLE;
        gnt_nx     = 4'b0000;
        z_valid_nx = 1'b0;
        busy_nx    = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mux4_sel_arbiter.md
# mux4_sel_arbiter

Round-robin arbiter and select sequencer for the 4->1 NAND-gate multiplexer (`mux4`). Four requesters compete for the shared mux output. The arbiter drives the mux `sel` lines and a one-hot grant. It holds off `z_valid` for a programmable settle window after every select change, so that downstream logic never samples `z` while the NAND paths are still propagating. It sits directly beside the `mux4` instance, with `sel` wired straight to `mux4.sel`.

## Interface
Parameters:
- SETTLE_CYCLES, 2, number of clocks spent in SETTLE after each select change; legal range 1..15, 0 is illegal.
- QUANTUM, 8, maximum number of GRANT cycles while another requester is waiting; 0 = unlimited, legal range 0..255.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request per mux input; req[i] requests d<i>; held high for as long as access is wanted.
- sel  out  2  select to mux4; registered.
- gnt  out  4  one-hot grant, gnt[i] corresponds to sel==i; all-zero when idle; registered.
- z_valid  out  1  mux output is settled and belongs to the granted requester; registered.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, SETTLE, GRANT. Internal state: `last` (2b, the last granted index), `scnt` (settle countdown), `qcnt` (quantum count).
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, sel=0, gnt=0000, z_valid=0, busy=0.
  - last=3, so that index 0 has first priority. scnt=0, qcnt=0.
- IDLE:
  - If req==0000, remain in IDLE. sel holds its previous value and is never forced back to 0; this avoids needless mux toggling.
  - Otherwise the winner is the first i with req[i]=1, searching last+1, last+2, last+3, last (mod 4).
  - On the next edge: sel=winner, gnt=onehot(winner), scnt=SETTLE_CYCLES-1, state=SETTLE.
- SETTLE:
  - gnt and busy are high; z_valid=0.
  - If req[sel]=0 (requester withdrew): release.
  - Else if scnt==0: state=GRANT, z_valid=1, qcnt=1.
  - Else scnt decrements.
- GRANT:
  - z_valid=1.
  - If req[sel]=0: release.
  - Else if QUANTUM!=0, qcnt==QUANTUM, and (req & ~gnt)!=0: forced release (preemption).
  - Else qcnt increments, saturating at QUANTUM; with QUANTUM=0 the counter is held and unused.
- Release, on one edge: gnt=0000, z_valid=0, last=sel, state=IDLE. sel is unchanged.
- Arbitration happens only in IDLE, so there is always exactly one IDLE cycle between consecutive grants.
- A request that rises during SETTLE or GRANT is ignored until the next IDLE.
- Fairness: a requester that is continuously asserting waits at most 3 grants before it is served.

## Timing
- Edge numbering: req sampled at edge E.
  - E+0: gnt/sel/busy change.
  - E+SETTLE_CYCLES: z_valid rises.
  - The SETTLE state lasts exactly SETTLE_CYCLES cycles.
- With QUANTUM=Q and contention, z_valid is high for exactly Q cycles. The forced release occurs at the edge ending the Q-th GRANT cycle.
- Dropping req[sel] while in GRANT: gnt and z_valid fall at the first edge that samples req[sel]=0.
- The next grant to another waiting requester appears 2 edges after the release edge samples the drop: release edge, then IDLE arbitration edge.
- sel changes only on an IDLE->SETTLE edge. gnt and sel always agree whenever gnt!=0.
- rst asserted asynchronously between edges: all outputs take their reset values immediately, without waiting for clk. Deassertion is synchronous to clk; the first arbitration occurs at the first edge after rst falls.

## Test plan
- Reset and first grant:
  - rst pulse mid-GRANT -> outputs 0 and busy=0 immediately.
  - Then req=1111 -> sel=0, gnt=0001 one edge after sampling; z_valid=1 after 2 more edges (SETTLE_CYCLES=2).
- Round-robin order with req=1111 held, QUANTUM=4:
  - Grants run 0,1,2,3,0.
  - Each grant has z_valid high for exactly 4 cycles.
  - There is exactly 1 IDLE cycle between grants and no overlap of gnt bits.
- Voluntary release:
  - Grant 2 (req=0100), then req=1000 while still in GRANT.
  - Result: gnt 0100 -> 0000 at the next edge, then 1000 one edge later, with sel 2->3.
  - z_valid stays low for SETTLE_CYCLES cycles after the change.
- Withdraw during SETTLE:
  - req=0010 for 1 cycle only, SETTLE_CYCLES=3.
  - Result: gnt=0010 for 1 cycle, z_valid never rises, last=1.
  - A subsequent req=0011 is granted to index 0 first.
- No contention, QUANTUM=4:
  - req=0001 held for 20 cycles.
  - Result: the grant is never preempted and z_valid stays high continuously until req drops.
- QUANTUM=0 with req=1111:
  - Index 0 holds the grant indefinitely.
  - Dropping req[0] passes the grant to index 1.
